// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package s2p_pkg;

  typedef enum logic [1:0] {
    S2P_IDLE    = 2'd0,
    S2P_COLLECT = 2'd1,
    S2P_PARITY  = 2'd2
  } s2p_state_t;

  // Bit-counter width: must be able to hold 'width' itself, which is the
  // count while waiting for the parity bit.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// One-entry valid/ready holding register with drop-on-full overflow flag.
// Latency: 1 clock from load_vld to out_vld.
// Backpressure: none upstream; a load into a full, non-draining register is dropped and flagged.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load_vld      a completed word is offered this cycle
//   load_dat      the offered word
//   out_vld       register holds a word
//   out_rdy       downstream accepts (transfer = out_vld & out_rdy)
//   out_dat       held word, stable while out_vld & !out_rdy
//   ovf           one-cycle pulse after a dropped load
module s2p_out_reg #(
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_vld,
  input  logic [dw-1:0] load_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [dw-1:0] out_dat,
  output logic          ovf
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      ovf     <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (load_vld) begin
        // A same-cycle transfer frees the slot, so the new word can replace it.
        if (!out_vld || out_rdy) begin
          out_vld <= 1'b1;
          out_dat <= load_dat;
        end else begin
          ovf <= 1'b1;
        end
      end else if (out_vld && out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel deserializer with one-entry valid/ready output.
// Latency: 1 clock from the cycle the final bit is sampled to parallel_valid.
// Backpressure: never stalls the serial side; a word completing into a full register is dropped (overflow pulse).
//
// Optional feature macro: S2P_PARITY_EN -- one even-parity bit follows each
// word; the word completes on that bit and parallel_err reports a mismatch.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   serial_valid    serial_data carries a bit this cycle
//   serial_data     serial bit, first bit of a word lands in parallel_data[0]
//   parallel_valid  output register holds a word
//   parallel_ready  downstream accepts
//   parallel_data   assembled word
//   parallel_err    parity error for the presented word (0 without the macro)
//   busy            partial word in progress
//   overflow        one-cycle pulse: completed word dropped
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_valid,
  input  logic             serial_data,
  output logic             parallel_valid,
  input  logic             parallel_ready,
  output logic [width-1:0] parallel_data,
  output logic             parallel_err,
  output logic             busy,
  output logic             overflow
);

  localparam int CW = cnt_w(width);
  localparam logic [CW-1:0] LAST = CW'(width - 1);
`ifdef S2P_PARITY_EN
  localparam logic [CW-1:0] FULL = CW'(width);
  localparam int OW = width + 1;
`else
  localparam int OW = width;
`endif

  s2p_state_t       state;
  logic [CW-1:0]    cnt;
  logic [width-1:0] shift_reg;
  logic [width-1:0] msb_bit;
  logic [width-1:0] shift_nxt;
  logic             data_bit;
  logic             complete;
  logic [width-1:0] word;
  logic [OW-1:0]    load_dat;
  logic [OW-1:0]    out_dat;

  // New bit enters at the MSB and everything moves down, so after 'width'
  // bits the first one received sits in bit 0. Built without slicing so
  // width=1 stays legal.
  always_comb begin
    msb_bit = '0;
    msb_bit[width-1] = serial_data;
    shift_nxt = (shift_reg >> 1) | msb_bit;
  end

  assign data_bit = serial_valid && (state != S2P_PARITY);

`ifdef S2P_PARITY_EN
  logic word_err;
  assign complete = serial_valid && (state == S2P_PARITY);
  assign word     = shift_reg;
  // Even parity: data XOR parity bit must be zero.
  assign word_err = (^shift_reg) ^ serial_data;
  assign load_dat = {word_err, word};
  assign parallel_err = out_dat[width];
`else
  assign complete = data_bit && (cnt == LAST);
  // The final bit is still in flight this cycle, so present the shifted value.
  assign word     = shift_nxt;
  assign load_dat = word;
  assign parallel_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S2P_IDLE;
      cnt       <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        S2P_IDLE, S2P_COLLECT: begin
          if (data_bit) begin
            shift_reg <= shift_nxt;
            if (cnt == LAST) begin
`ifdef S2P_PARITY_EN
              state <= S2P_PARITY;
              cnt   <= FULL;
`else
              state <= S2P_IDLE;
              cnt   <= '0;
`endif
            end else begin
              state <= S2P_COLLECT;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        S2P_PARITY: begin
          if (serial_valid) begin
            state <= S2P_IDLE;
            cnt   <= '0;
          end
        end
        default: state <= S2P_IDLE;
      endcase
    end
  end

  assign busy = (cnt != '0);

  s2p_out_reg #(
    .dw(OW)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load_vld (complete),
    .load_dat (load_dat),
    .out_vld  (parallel_valid),
    .out_rdy  (parallel_ready),
    .out_dat  (out_dat),
    .ovf      (overflow)
  );

  assign parallel_data = out_dat[width-1:0];

endmodule

// File: tb/tb_serial_to_parallel.sv
module tb_serial_to_parallel;

  localparam int WIDTH = 8;
`ifdef S2P_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             serial_valid = 1'b0;
  logic             serial_data = 1'b0;
  logic             parallel_ready = 1'b0;
  logic             parallel_valid;
  logic [WIDTH-1:0] parallel_data;
  logic             parallel_err;
  logic             busy;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  serial_to_parallel #(.width(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_valid   (serial_valid),
    .serial_data    (serial_data),
    .parallel_valid (parallel_valid),
    .parallel_ready (parallel_ready),
    .parallel_data  (parallel_data),
    .parallel_err   (parallel_err),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: word-level view of the link.
  int               m_cnt;       // bits of the current word received so far
  logic [WIDTH-1:0] m_bits;      // data bits received, indexed by arrival order
  logic             m_full;      // a word is waiting downstream
  logic [WIDTH-1:0] m_word;
  logic             m_err;
  logic             m_ovf;       // a word was dropped at the last edge
  int               m_ovf_cnt;
  logic [WIDTH-1:0] exp_q[$];    // words the model says leave the DUT
  logic [WIDTH-1:0] got_q[$];    // words observed leaving the DUT
  int               ovf_cnt;
  bit               bitq[$];     // serial bits queued for transmission

  // Observed transfers and overflow pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (parallel_valid && parallel_ready) got_q.push_back(parallel_data);
      if (overflow) ovf_cnt++;
    end
  end

`ifdef S2P_PARITY_EN
  function automatic void append_word(input logic [WIDTH-1:0] w, input logic flip = 1'b0);
    for (int k = 0; k < WIDTH; k++) bitq.push_back(w[k]);
    bitq.push_back((^w) ^ flip);
  endfunction
`else
  function automatic void append_word(input logic [WIDTH-1:0] w);
    for (int k = 0; k < WIDTH; k++) bitq.push_back(w[k]);
  endfunction
`endif

  task automatic do_reset();
    rst = 1'b1;
    serial_valid = 1'b0;
    serial_data = 1'b0;
    parallel_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_cnt = 0; m_bits = '0; m_full = 1'b0; m_word = '0; m_err = 1'b0;
    m_ovf = 1'b0; m_ovf_cnt = 0; ovf_cnt = 0;
    exp_q.delete(); got_q.delete(); bitq.delete();
  endtask

  // Drive one cycle and advance the model across the same clock edge.
  task automatic step(input logic sv, input logic sd, input logic rdy);
    logic             complete;
    logic [WIDTH-1:0] w;
    logic             e;
    serial_valid = sv;
    serial_data = sd;
    parallel_ready = rdy;
    complete = 1'b0;
    w = '0;
    e = 1'b0;
    if (sv) begin
      if (m_cnt < WIDTH) m_bits[m_cnt] = sd;
      else e = (^m_bits) ^ sd;
      m_cnt++;
      if (m_cnt == NB) begin
        complete = 1'b1;
        w = m_bits;
        m_cnt = 0;
        m_bits = '0;
      end
    end
    m_ovf = 1'b0;
    if (m_full && rdy) begin
      exp_q.push_back(m_word);
      m_full = 1'b0;
    end
    if (complete) begin
      if (!m_full) begin
        m_full = 1'b1; m_word = w; m_err = e;
      end else begin
        m_ovf = 1'b1; m_ovf_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic play(input logic rdy);
    while (bitq.size() > 0) step(1'b1, bitq.pop_front(), rdy);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (parallel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", parallel_valid); end
    checks++; if (parallel_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 00", parallel_data); end
    checks++; if (parallel_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", parallel_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_basic();
    do_reset();
    append_word(8'hA5);
    play(1'b1);
    checks++; if (parallel_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", parallel_valid); end
    checks++; if (parallel_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", parallel_data); end
    checks++; if (parallel_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", parallel_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (parallel_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b exp 0", parallel_valid); end
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin errors++; $display("FAIL basic_delivered got n=%0d exp n=1 word a5", got_q.size()); end
  endtask

  task automatic test_gaps();
    int k;
    do_reset();
    append_word(8'hA5);
    k = 0;
    while (bitq.size() > 0) begin
      repeat (k % 4) begin
        step(1'b0, 1'b0, 1'b1);
        if (k > 0) begin
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gaps_busy bit=%0d got %b exp 1", k, busy); end
        end
      end
      step(1'b1, bitq.pop_front(), 1'b1);
      k++;
    end
    checks++; if (parallel_valid !== 1'b1 || parallel_data !== 8'hA5) begin errors++; $display("FAIL gaps_word got v=%b d=%h exp v=1 d=a5", parallel_valid, parallel_data); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin errors++; $display("FAIL gaps_delivered got n=%0d exp n=1 word a5", got_q.size()); end
  endtask

  task automatic test_overflow();
    int cyc;
    do_reset();
    append_word(8'h3C);
    append_word(8'hC3);
    cyc = 0;
    while (bitq.size() > 0) begin
      step(1'b1, bitq.pop_front(), 1'b0);
      cyc++;
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b exp 1", overflow); end
    checks++; if (parallel_valid !== 1'b1 || parallel_data !== 8'h3C) begin errors++; $display("FAIL ovf_hold got v=%b d=%h exp v=1 d=3c", parallel_valid, parallel_data); end
    step(1'b0, 1'b0, 1'b0);
    cyc++;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end got %b exp 0", overflow); end
    while (cyc < 20) begin step(1'b0, 1'b0, 1'b0); cyc++; end
    checks++; if (parallel_data !== 8'h3C) begin errors++; $display("FAIL ovf_stable got %h exp 3c", parallel_data); end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    checks++; if (parallel_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", parallel_valid); end
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin errors++; $display("FAIL ovf_delivered got n=%0d exp n=1 word 3c", got_q.size()); end
    checks++; if (ovf_cnt != 1) begin errors++; $display("FAIL ovf_count got %0d exp 1", ovf_cnt); end
  endtask

  task automatic test_same_cycle();
    int total;
    do_reset();
    append_word(8'h3C);
    append_word(8'hC3);
    total = bitq.size();
    for (int i = 0; i < total; i++) step(1'b1, bitq.pop_front(), (i == total - 1));
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL same_ovf got %b exp 0", overflow); end
    checks++; if (parallel_valid !== 1'b1 || parallel_data !== 8'hC3) begin errors++; $display("FAIL same_word got v=%b d=%h exp v=1 d=c3", parallel_valid, parallel_data); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (parallel_valid !== 1'b0) begin errors++; $display("FAIL same_drop got %b exp 0", parallel_valid); end
    checks++; if (got_q.size() != 2 || got_q[0] !== 8'h3C || got_q[1] !== 8'hC3) begin errors++; $display("FAIL same_delivered got n=%0d exp n=2 words 3c c3", got_q.size()); end
    checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL same_ovf_count got %0d exp 0", ovf_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    append_word(8'h5A);
    play(1'b0);
    append_word(8'hFF);
    repeat (4) step(1'b1, bitq.pop_front(), 1'b0);
    do_reset();
    checks++; if (parallel_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", parallel_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    append_word(8'h81);
    play(1'b1);
    step(1'b0, 1'b0, 1'b1);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h81) begin errors++; $display("FAIL mid_delivered got n=%0d exp n=1 word 81", got_q.size()); end
  endtask

`ifdef S2P_PARITY_EN
  task automatic test_parity();
    do_reset();
    append_word(8'hA5, 1'b0);
    play(1'b1);
    checks++; if (parallel_valid !== 1'b1 || parallel_err !== 1'b0) begin errors++; $display("FAIL par_good got v=%b e=%b exp v=1 e=0", parallel_valid, parallel_err); end
    append_word(8'hA5, 1'b1);
    play(1'b1);
    checks++; if (parallel_err !== 1'b1) begin errors++; $display("FAIL par_bad_err got %b exp 1", parallel_err); end
    checks++; if (parallel_data !== 8'hA5) begin errors++; $display("FAIL par_bad_data got %h exp a5", parallel_data); end
  endtask
`endif

  task automatic test_random();
    logic sv, sd, rdy;
    logic [WIDTH-1:0] w;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      sv = ($urandom_range(0, 3) != 0);
      // Alternate stretches of scarce and plentiful ready to provoke drops.
      if (((c / 60) % 2) == 1) rdy = ($urandom_range(0, 7) == 0);
      else rdy = ($urandom_range(0, 2) != 0);
      if (sv && bitq.size() == 0) begin
        w = WIDTH'($urandom);
`ifdef S2P_PARITY_EN
        append_word(w, 1'($urandom_range(0, 1)));
`else
        append_word(w);
`endif
      end
      sd = sv ? bitq.pop_front() : 1'($urandom_range(0, 1));
      step(sv, sd, rdy);
      checks++; if (parallel_valid !== m_full) begin errors++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, parallel_valid, m_full); end
      if (m_full) begin
        checks++; if (parallel_data !== m_word) begin errors++; $display("FAIL rnd_data c=%0d got %h exp %h", c, parallel_data, m_word); end
        checks++; if (parallel_err !== m_err) begin errors++; $display("FAIL rnd_err c=%0d got %b exp %b", c, parallel_err, m_err); end
      end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow c=%0d got %b exp %b", c, overflow, m_ovf); end
      checks++; if (busy !== (m_cnt != 0)) begin errors++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, busy, (m_cnt != 0)); end
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_word i=%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (ovf_cnt != m_ovf_cnt) begin errors++; $display("FAIL rnd_ovf_count got %0d exp %0d", ovf_cnt, m_ovf_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_same_cycle();
    test_reset_mid();
`ifdef S2P_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
